// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load extraction and writeback select.
// Optional write-through bypass to decode: define WB_BYPASS_EN.
module wb_stage #(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                RegWrite_in,
  input  logic                MemtoReg_in,
  input  logic                Link_in,
  input  logic [1:0]          Mem_size_in,
  input  logic                Mem_sign_in,
  input  logic [4:0]          Write_addr_in,
  input  logic [bit_size-1:0] ALU_result_in,
  input  logic [bit_size-1:0] Mem_data_in,
  input  logic [bit_size-1:0] PC_plus4_in,
`ifdef WB_BYPASS_EN
  input  logic [4:0]          Read_addr_1,
  input  logic [4:0]          Read_addr_2,
  input  logic [bit_size-1:0] Reg_data_1,
  input  logic [bit_size-1:0] Reg_data_2,
  output logic [bit_size-1:0] Fwd_data_1,
  output logic [bit_size-1:0] Fwd_data_2,
`endif
  output logic                wb_valid,
  output logic                RegWrite,
  output logic [4:0]          Write_addr,
  output logic [bit_size-1:0] Write_data
);

  logic [1:0]          off;
  logic [7:0]          byte_l;
  logic [15:0]         half_l;
  logic [bit_size-1:0] load_data;
  logic [bit_size-1:0] sel_data;

  logic                valid_q, valid_d;
  logic                rw_q, rw_d;
  logic [4:0]          addr_q, addr_d;
  logic [bit_size-1:0] data_q, data_d;

  assign off = ALU_result_in[1:0];

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_l    = Mem_data_in[7:0];
    half_l    = off[1] ? Mem_data_in[31:16] : Mem_data_in[15:0];
    load_data = Mem_data_in;
    unique case (off)
      2'd0: byte_l = Mem_data_in[7:0];
      2'd1: byte_l = Mem_data_in[15:8];
      2'd2: byte_l = Mem_data_in[23:16];
      2'd3: byte_l = Mem_data_in[31:24];
    endcase
    unique case (Mem_size_in)
      2'b00:
        load_data = {{(bit_size-8){Mem_sign_in & byte_l[7]}},
                     byte_l};
      2'b01:
        load_data = {{(bit_size-16){Mem_sign_in & half_l[15]}},
                     half_l};
      default:
        load_data = Mem_data_in;
    endcase
  end

  // Writeback source: link beats load beats ALU.
  always_comb begin
    sel_data = ALU_result_in;
    if (Link_in)
      sel_data = PC_plus4_in;
    else if (MemtoReg_in)
      sel_data = load_data;
  end

  // Next state: reset beats flush beats stall beats load.
  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (rst || flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      rw_d    = in_valid & RegWrite_in &
                (Write_addr_in != 5'd0);
      addr_d  = Write_addr_in;
      data_d  = sel_data;
    end
  end

  // Stage register.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    data_q  <= data_d;
  end

  assign wb_valid   = valid_q;
  assign RegWrite   = rw_q;
  assign Write_addr = addr_q;
  assign Write_data = data_q;

`ifdef WB_BYPASS_EN
  // Same-cycle write-through so decode sees the value being written.
  always_comb begin
    Fwd_data_1 = Reg_data_1;
    Fwd_data_2 = Reg_data_2;
    if (rw_q && addr_q == Read_addr_1)
      Fwd_data_1 = data_q;
    if (rw_q && addr_q == Read_addr_2)
      Fwd_data_2 = data_q;
  end
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback select logic for the 5-stage MIPS pipeline.
- Captures memory-stage results on each clock edge. Performs load byte/halfword extraction and sign/zero extension. Selects the writeback source among ALU result, load data and link address.
- Drives the register file write port (RegWrite, Write_addr, Write_data) one cycle after capture.

Parameters:
- bit_size, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  synchronous reset, active-high
- stall  input  1  hold all stage registers
- flush  input  1  squash the incoming instruction (insert bubble)
- in_valid  input  1  MEM stage holds a real instruction
- RegWrite_in  input  1  instruction writes a register
- MemtoReg_in  input  1  writeback source is load data
- Link_in  input  1  writeback source is PC+4 (jal/jalr)
- Mem_size_in  input  2  load size: 00 byte, 01 half, 10 word, 11 word
- Mem_sign_in  input  1  1 = sign-extend sub-word load, 0 = zero-extend
- Write_addr_in  input  5  destination register
- ALU_result_in  input  bit_size  ALU result; bits [1:0] give the load byte offset
- Mem_data_in  input  bit_size  raw aligned memory word, little-endian lanes
- PC_plus4_in  input  bit_size  link address
- wb_valid  output  1  registered valid of the WB-stage instruction
- RegWrite  output  1  register file write enable
- Write_addr  output  5  register file write address
- Write_data  output  bit_size  register file write data

Behaviour:
- Fixed by the pipeline: single clock domain clk; rst is synchronous and active-high. No asynchronous reset path.
- All outputs are registered. Latency is 1 cycle from input to output.
- Priority at each rising clk edge: rst > flush > stall > load.
  - rst: wb_valid=0, RegWrite=0, Write_addr=0, Write_data=0.
  - flush (stall ignored): wb_valid=0, RegWrite=0. Write_addr and Write_data are loaded to 0.
  - stall: all registers hold their values. RegWrite keeps its value, so the regfile rewrites the same value, which is harmless.
  - load:
    - wb_valid <= in_valid.
    - RegWrite <= in_valid & RegWrite_in & (Write_addr_in != 0).
    - Write_addr <= Write_addr_in.
    - Write_data <= selected data.
- Writes to register $0 are always suppressed via RegWrite=0. Write_data is still loaded.
- Source select priority: Link_in > MemtoReg_in > ALU_result_in.
  - Link_in=1 selects PC_plus4_in.
  - MemtoReg_in=1 selects the load data below.
- Load extraction, with off = ALU_result_in[1:0]:
  - byte: lane = Mem_data_in[8*off+7 : 8*off]. Extend bit 7 if Mem_sign_in, else zero.
  - half: off[1]=0 takes [15:0], off[1]=1 takes [31:16]; off[0] is ignored (misalignment is trapped upstream). Extend bit 15 if Mem_sign_in, else zero.
  - word (10 or 11): Mem_data_in unchanged; Mem_sign_in ignored.
- Control inputs arriving with in_valid=0 never cause a write, whatever RegWrite_in says.
- rst asserted mid-stall or mid-flush: the reset values win on that edge. The first capture happens on the first edge after rst deasserts.
- No combinational path from any input to any output, except the optional bypass below.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds these ports:
  - Read_addr_1, Read_addr_2: input, 5 bits
  - Reg_data_1, Reg_data_2: input, bit_size (regfile read outputs)
  - Fwd_data_1, Fwd_data_2: output, bit_size
- Bypass rule: Fwd_data_x = Write_data when RegWrite=1 and Write_addr==Read_addr_x; otherwise Fwd_data_x = Reg_data_x.
  - The path is combinational and gives same-cycle write-through for the decode stage.
  - Read_addr_x=0 always returns Reg_data_x, because RegWrite is never 1 for address 0.
- Not defined: these ports and logic are absent. Decode sees the regfile value, and the hazard unit must stall one extra cycle on a WB-to-ID dependency.

Test Plan:
- Reset and ALU pass: assert rst 2 cycles → all outputs 0. Then in_valid=1, RegWrite_in=1, Write_addr_in=5, ALU_result_in=0x0000_1234 → next cycle RegWrite=1, Write_addr=5, Write_data=0x0000_1234, wb_valid=1.
- Load extraction: Mem_data_in=0x80FF_7F01, MemtoReg_in=1:
  - lb, off=3 → 0xFFFF_FF80
  - lbu, off=3 → 0x0000_0080
  - lh, off=2 → 0xFFFF_80FF
  - lhu, off=0 → 0x0000_7F01
  - lw → 0x80FF_7F01
- $0 and invalid suppression:
  - Write_addr_in=0, RegWrite_in=1, valid → RegWrite=0.
  - in_valid=0, RegWrite_in=1, Write_addr_in=7 → RegWrite=0, wb_valid=0.
- Link priority: Link_in=1, MemtoReg_in=1, PC_plus4_in=0x0040_0008, Write_addr_in=31 → Write_data=0x0040_0008, Write_addr=31.
- Stall/flush/reset priority:
  - Stall 3 cycles with changing inputs → outputs frozen at the prior values.
  - flush=1 together with stall=1 → RegWrite=0, wb_valid=0 next cycle.
  - rst=1 together with a valid load → all outputs 0.
- WB_BYPASS_EN defined: RegWrite=1, Write_addr=9, Write_data=0xDEAD_BEEF, Read_addr_1=9, Reg_data_1=0x1, Read_addr_2=10, Reg_data_2=0x2 → Fwd_data_1=0xDEAD_BEEF, Fwd_data_2=0x2.
